// File: rtl/ahb_sram_slave_if_if.sv
// AHB-Lite bus bundle for the SRAM slave front end.
// The master modport is the interconnect/bench side, the slave modport is
// the ahb_sram_slave_if side.
interface ahb_sram_slave_if_if #(
  parameter int AHB_DWIDTH = 32
) ();
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic                  HREADY;
  logic [AHB_DWIDTH-1:0] HWDATA;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [AHB_DWIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave front end for the on-chip SRAM path.
// Each accepted transfer becomes a one-cycle ahbsram_req pulse; wait states
// are inserted until the SRAM controller acks. With the controller's fixed
// one-cycle ack latency every data phase lasts 3 cycles.
// Optional feature: define AHB_SRAM_ALIGN_CHK_EN to answer misaligned
// transfers with a two-cycle ERROR response instead of forwarding them.
module ahb_sram_slave_if #(
  parameter int AHB_DWIDTH = 32,
  parameter int ADD_WIDTH  = 11
) (
  input  logic                  HCLK,
  input  logic                  aresetn,
  ahb_sram_slave_if_if.slave    ahb,
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [2:0]            ahbsram_size,
  output logic [ADD_WIDTH-1:0]  ahbsram_addr,
  output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
  input  logic                  sramahb_ack,
  input  logic [AHB_DWIDTH-1:0] sramahb_rdata
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t                 state_r;
  logic                   hreadyout_r;
  logic [1:0]             hresp_r;
  logic                   req_r;
  logic                   write_r;
  logic [2:0]             size_r;
  logic [ADD_WIDTH-1:0]   addr_r;
  logic                   valid_s;
  logic                   misalign_s;
  logic                   unused_s;

`ifdef AHB_SRAM_ALIGN_CHK_EN
  // A transfer is misaligned when its address is not a multiple of its size;
  // anything wider than a word cannot be served on a 32-bit bus.
  function automatic logic misaligned_f(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr_lo[0];
      3'b010:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction
`endif

  assign valid_s = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

  // Flag address phases that must be answered with an error response.
  always_comb begin
`ifdef AHB_SRAM_ALIGN_CHK_EN
    misalign_s = misaligned_f(ahb.HSIZE, ahb.HADDR[1:0]);
`else
    misalign_s = 1'b0;
`endif
  end

  // Transfer FSM: state, registered bus response, command pulse and the
  // latched address-phase attributes (held until the next accepted phase).
  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= RESP_OKAY;
      req_r       <= 1'b0;
      write_r     <= 1'b0;
      size_r      <= 3'b000;
      addr_r      <= {ADD_WIDTH{1'b0}};
    end else begin
      req_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ERR2: begin
          if (valid_s) begin
            addr_r  <= ahb.HADDR[ADD_WIDTH-1:0];
            size_r  <= ahb.HSIZE;
            write_r <= ahb.HWRITE;
            if (misalign_s) begin
              state_r     <= ST_ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= RESP_ERROR;
            end else begin
              state_r     <= ST_REQ;
              req_r       <= 1'b1;
              hreadyout_r <= 1'b0;
              hresp_r     <= RESP_OKAY;
            end
          end else begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= RESP_OKAY;
          end
        end
        ST_REQ: begin
          state_r     <= ST_WAIT;
          hreadyout_r <= 1'b0;
          hresp_r     <= RESP_OKAY;
        end
        ST_WAIT: begin
          if (sramahb_ack) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
          end else begin
            state_r     <= ST_WAIT;
            hreadyout_r <= 1'b0;
          end
          hresp_r <= RESP_OKAY;
        end
        ST_ERR1: begin
          state_r     <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= RESP_ERROR;
        end
        default: begin
          state_r     <= ST_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= RESP_OKAY;
        end
      endcase
    end
  end

  assign ahb.HREADYOUT  = hreadyout_r;
  assign ahb.HRESP      = hresp_r;
  assign ahb.HRDATA     = sramahb_rdata;
  assign ahbsram_req    = req_r;
  assign ahbsram_write  = write_r;
  assign ahbsram_size   = size_r;
  assign ahbsram_addr   = addr_r;
  assign ahbsram_wdata  = ahb.HWDATA;

  // Upper address bits alias the SRAM; HTRANS[0] only separates SEQ/NONSEQ.
  assign unused_s = ^{ahb.HADDR[31:ADD_WIDTH], ahb.HTRANS[0]};

endmodule

// File: doc/ahb_sram_slave_if.md
# ahb_sram_slave_if

AHB-Lite slave front end for the on-chip SRAM path. It accepts AHB-Lite transfers, converts each one into a single-cycle `ahbsram_req` command for the downstream SRAM controller interface, and inserts wait states until that controller acks. It then returns read data and the response. It sits between the AHB interconnect and the SRAM controller interface.

## Interface
- `AHB_DWIDTH`, 32: data width; only 32 is supported.
- `ADD_WIDTH`, 11: SRAM byte-address width forwarded downstream.

- `HCLK` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low; clock HCLK.
- `HSEL` in 1: slave select.
- `HADDR` in 32: byte address.
- `HTRANS` in 2: transfer type; bit 1 set = NONSEQ/SEQ.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: transfer size.
- `HREADY` in 1: bus ready, used to qualify address phases.
- `HWDATA` in AHB_DWIDTH: write data, valid in the data phase.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 2: 00 = OKAY, 01 = ERROR.
- `HRDATA` out AHB_DWIDTH: read data.
- `ahbsram_req` out 1: one-cycle command pulse.
- `ahbsram_write` out 1: command direction.
- `ahbsram_size` out 3: registered HSIZE.
- `ahbsram_addr` out ADD_WIDTH: registered HADDR[ADD_WIDTH-1:0].
- `ahbsram_wdata` out AHB_DWIDTH: equals HWDATA (combinational).
- `sramahb_ack` in 1: command complete.
- `sramahb_rdata` in AHB_DWIDTH: read data, valid the cycle after ack.

## Operation
- A valid address phase is `HSEL & HREADY & HTRANS[1]` at a rising HCLK edge. On it, HADDR[ADD_WIDTH-1:0], HWRITE and HSIZE are registered. Upper address bits are ignored, so the SRAM aliases.
- IDLE, BUSY and unselected transfers get a zero-wait OKAY. No command is issued.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=OKAY. A valid address phase goes to REQ, or to ERR1 for a flagged transfer (see Configuration).
  - REQ: `ahbsram_req`=1, HREADYOUT=0. Always goes to WAIT.
  - WAIT: HREADYOUT=0. `sramahb_ack`=1 goes to IDLE; otherwise it stays, with no timeout.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Goes to REQ, ERR1 or IDLE by the same rule as IDLE.
- HREADYOUT and HRESP are registered, decoded from state.
- `ahbsram_addr`, `ahbsram_size` and `ahbsram_write` hold stable from REQ until the next valid address phase.
- `sramahb_ack` outside WAIT is ignored.
- `HRDATA` = `sramahb_rdata` continuously.
- Reset values: HREADYOUT=1, HRESP=00, `ahbsram_req`=0, `ahbsram_addr`/`ahbsram_size`/`ahbsram_write`=0, state IDLE. HRDATA follows downstream, which resets to 0.
- Reset mid-transfer returns the block to IDLE immediately. The in-flight command is abandoned.

## Timing
- Cycle A: address phase, sampled at the end of A.
- Cycle D0: `ahbsram_req`=1 and HWDATA is presented downstream.
- Cycle D1: ack from the downstream controller.
- Cycle D2: HREADYOUT=1; for a read, HRDATA holds valid data.
- Every read or write data phase therefore lasts 3 cycles (2 wait states), given the controller's fixed one-cycle ack latency.
- Back-to-back: the next address phase is sampled in D2, and its D0 is the following cycle. Throughput is one transfer per 3 cycles.
- The error response is two cycles: ERR1 then ERR2.

## Configuration
- `AHB_SRAM_ALIGN_CHK_EN`
  - Defined: a valid address phase that is misaligned goes to ERR1 and issues no `ahbsram_req`. Misaligned means HSIZE=001 with HADDR[0]=1, HSIZE=010 with HADDR[1:0]≠0, or HSIZE≥011.
  - Undefined: every valid transfer is forwarded unchanged. ERR1/ERR2 are unreachable and HRESP is constant 00.

## Test plan
- Word write: addr 0x10, data 0xDEADBEEF -> `ahbsram_req` one cycle in D0 with addr 0x10, size 010, wdata 0xDEADBEEF; HREADYOUT low 2 cycles; OKAY.
- Word read of 0x10 after that write -> HRDATA=0xDEADBEEF in D2 with HREADYOUT=1.
- Byte write 0xAB to 0x13, then word read of 0x10 -> 0xABADBEEF.
- Back-to-back write 0x20 then read 0x20 -> second address phase sampled in D2; exactly two req pulses 3 cycles apart; read returns the written data.
- With `AHB_SRAM_ALIGN_CHK_EN`, halfword at 0x21 -> no req; HRESP=01 for 2 cycles, HREADYOUT 0 then 1. Without the macro -> normal OKAY transfer.
- `aresetn` pulsed low during WAIT -> HREADYOUT=1 and req=0 immediately; a subsequent write completes normally.
